// File: rtl/and_or_arbiter_pkg.sv
// rtl/and_or_arbiter_pkg.sv - shared width default, FSM state and op encodings
package and_or_arbiter_pkg;

  localparam int AO_WIDTH = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam logic OP_AND = 1'b1;
  localparam logic OP_OR  = 1'b0;

endpackage

// File: rtl/and_or_arbiter_if.sv
// rtl/and_or_arbiter_if.sv - two-requester operation/response bus
interface and_or_arbiter_if
  import and_or_arbiter_pkg::*;
#(
  parameter int WIDTH = AO_WIDTH
) ();

  logic             req0Valid, req1Valid;
  logic             req0Ready, req1Ready;
  logic [WIDTH-1:0] req0A, req0B, req1A, req1B;
  logic             req0Op, req1Op;
  logic             rsp0Valid, rsp1Valid;
  logic             rsp0Ready, rsp1Ready;
  logic [WIDTH-1:0] rspData;
  logic             rspIsAnd;
  logic             busy;
  logic             errFlag;

  modport master (
    output req0Valid, req1Valid, req0A, req0B, req1A, req1B, req0Op, req1Op,
    output rsp0Ready, rsp1Ready,
    input  req0Ready, req1Ready, rsp0Valid, rsp1Valid, rspData, rspIsAnd,
    input  busy, errFlag
  );

  modport slave (
    input  req0Valid, req1Valid, req0A, req0B, req1A, req1B, req0Op, req1Op,
    input  rsp0Ready, rsp1Ready,
    output req0Ready, req1Ready, rsp0Valid, rsp1Valid, rspData, rspIsAnd,
    output busy, errFlag
  );

endinterface

// File: rtl/and_or_arbiter_and_or.sv
// rtl/and_or_arbiter_and_or.sv - shared AND/OR datapath
module and_or #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             doAnd,
  input  logic             doOr,
  output logic [WIDTH-1:0] out,
  output logic             isAnd
);

  always_comb begin
    out = '0;
    if (doAnd) begin
      out = a & b;
    end else if (doOr) begin
      out = a | b;
    end
    isAnd = doAnd;
  end

endmodule

// File: rtl/and_or_arbiter.sv
// rtl/and_or_arbiter.sv - round-robin arbiter sharing one and_or between two requesters
module and_or_arbiter
  import and_or_arbiter_pkg::*;
#(
  parameter int WIDTH = AO_WIDTH
) (
  input  logic          clk,
  input  logic          rst,
  and_or_arbiter_if.slave bus
);

  state_t           state_q, state_d;
  logic             prio_q, prio_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic             op_q, op_d;
  logic             gnt_q, gnt_d;
  logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic             rsp_is_and_q, rsp_is_and_d;
  logic             err_q, err_d;

  logic             grant;
  logic             any_valid;
  logic             do_and, do_or;
  logic [WIDTH-1:0] ao_out;
  logic             ao_is_and;

  // With both requesters valid the priority pointer decides; otherwise the lone one wins.
  assign any_valid = bus.req0Valid | bus.req1Valid;
  assign grant     = (bus.req0Valid && bus.req1Valid) ? prio_q : bus.req1Valid;

  assign bus.req0Ready = !rst && (state_q == ST_IDLE) && any_valid && !grant;
  assign bus.req1Ready = !rst && (state_q == ST_IDLE) && any_valid &&  grant;
  assign bus.rsp0Valid = !rst && (state_q == ST_RESP) && !gnt_q;
  assign bus.rsp1Valid = !rst && (state_q == ST_RESP) &&  gnt_q;
  assign bus.busy      = !rst && (state_q != ST_IDLE);
  assign bus.rspData   = rsp_data_q;
  assign bus.rspIsAnd  = rsp_is_and_q;
  assign bus.errFlag   = err_q;

  always_comb begin
    state_d      = state_q;
    prio_d       = prio_q;
    a_d          = a_q;
    b_d          = b_q;
    op_d         = op_q;
    gnt_d        = gnt_q;
    rsp_data_d   = rsp_data_q;
    rsp_is_and_d = rsp_is_and_q;
    err_d        = err_q;
    do_and       = 1'b0;
    do_or        = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.req0Ready || bus.req1Ready) begin
          a_d     = grant ? bus.req1A  : bus.req0A;
          b_d     = grant ? bus.req1B  : bus.req0B;
          op_d    = grant ? bus.req1Op : bus.req0Op;
          gnt_d   = grant;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        do_and       = (op_q == OP_AND);
        do_or        = (op_q == OP_OR);
        rsp_data_d   = ao_out;
        rsp_is_and_d = ao_is_and;
        if (ao_is_and != op_q) begin
          err_d = 1'b1;
        end
        state_d = ST_RESP;
      end
      ST_RESP: begin
        if ((!gnt_q && bus.rsp0Ready) || (gnt_q && bus.rsp1Ready)) begin
          prio_d  = ~gnt_q;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      prio_q       <= 1'b0;
      a_q          <= '0;
      b_q          <= '0;
      op_q         <= 1'b0;
      gnt_q        <= 1'b0;
      rsp_data_q   <= '0;
      rsp_is_and_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      prio_q       <= prio_d;
      a_q          <= a_d;
      b_q          <= b_d;
      op_q         <= op_d;
      gnt_q        <= gnt_d;
      rsp_data_q   <= rsp_data_d;
      rsp_is_and_q <= rsp_is_and_d;
      err_q        <= err_d;
    end
  end

  and_or #(.WIDTH(WIDTH)) u_and_or (
    .a     (a_q),
    .b     (b_q),
    .doAnd (do_and),
    .doOr  (do_or),
    .out   (ao_out),
    .isAnd (ao_is_and)
  );

endmodule
